// File: rtl/ezusb_gpio_arbiter_pkg.sv
// Shared types and constants for the EZ-USB GPIO arbiter and its input debouncer.
package ezusb_gpio_arbiter_pkg;

    localparam int GPIO_W = 4;

    localparam int NREQ_MIN      = 2;
    localparam int NREQ_MAX      = 8;
    localparam int PULSE_LEN_MIN = 3;
    localparam int GAP_LEN_MIN   = 1;
    localparam int DEBOUNCE_MIN  = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Bits needed to hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        if (max_val < 1) return 1;
        return $clog2(max_val + 1);
    endfunction

    function automatic bit params_ok(input int nreq, input int pulse_len,
                                     input int gap_len, input int debounce);
        return (nreq >= NREQ_MIN) && (nreq <= NREQ_MAX) &&
               (pulse_len >= PULSE_LEN_MIN) && (gap_len >= GAP_LEN_MIN) &&
               (debounce >= DEBOUNCE_MIN);
    endfunction

endpackage

// File: rtl/ezusb_gpio_arbiter_gpio_debounce.sv
// Per-bit input debouncer: the filtered bit flips after DEBOUNCE consecutive
// disagreeing samples, with a rise/fall pulse on the flip cycle.
module gpio_debounce
    import ezusb_gpio_arbiter_pkg::*;
#(
    parameter int W        = 4,
    parameter int DEBOUNCE = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q,
    output logic [W-1:0] o_rise,
    output logic [W-1:0] o_fall
);

    localparam int CW = cnt_width(DEBOUNCE);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic [CW-1:0] r_cnt [W];
    logic [W-1:0]  r_q;
    logic [W-1:0]  r_rise;
    logic [W-1:0]  r_fall;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_q    <= '0;
            r_rise <= '0;
            r_fall <= '0;
            for (int b = 0; b < W; b++) r_cnt[b] <= '0;
        end else begin
            for (int b = 0; b < W; b++) begin
                r_rise[b] <= 1'b0;
                r_fall[b] <= 1'b0;
                if (i_d[b] == r_q[b]) begin
                    r_cnt[b] <= '0;
                end else if (r_cnt[b] == CNT_LAST) begin
                    // Counter stops at DEBOUNCE-1, so it can never wrap.
                    r_cnt[b]  <= '0;
                    r_q[b]    <= i_d[b];
                    r_rise[b] <= i_d[b];
                    r_fall[b] <= ~i_d[b];
                end else begin
                    r_cnt[b] <= r_cnt[b] + CW'(1);
                end
            end
        end
    end

    assign o_q    = r_q;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/ezusb_gpio_arbiter.sv
// Round-robin arbiter driving timed 4-bit pulses onto the wired-or GPIO
// outputs with readback check, plus debounced input events.
//
// state    | meaning
// ST_IDLE  | outputs released, waiting for a request
// ST_DRIVE | granted pattern driven for PULSE_LEN cycles
// ST_GAP   | outputs released for GAP_LEN cycles after done
module ezusb_gpio_arbiter
    import ezusb_gpio_arbiter_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int PULSE_LEN = 16,
    parameter int GAP_LEN   = 4,
    parameter int DEBOUNCE  = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [GPIO_W-1:0]        i_gpio_in,
    output logic [GPIO_W-1:0]        o_gpio_out,
    input  logic [NREQ-1:0]          i_req,
    input  logic [GPIO_W*NREQ-1:0]   i_pattern,
    output logic [NREQ-1:0]          o_gnt,
    output logic [NREQ-1:0]          o_done,
    output logic                     o_err,
    output logic [GPIO_W-1:0]        o_err_mask,
    output logic                     o_busy,
    output logic [GPIO_W-1:0]        o_in_filt,
    output logic [GPIO_W-1:0]        o_rise,
    output logic [GPIO_W-1:0]        o_fall
);

    localparam int PTR_W = $clog2(NREQ);
    localparam int TMR_W = cnt_width((PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN);

    if (!params_ok(NREQ, PULSE_LEN, GAP_LEN, DEBOUNCE)) begin : g_param_check
        $error("ezusb_gpio_arbiter: illegal parameter combination");
    end

    state_t              r_state;
    logic [PTR_W-1:0]    r_ptr;
    logic [PTR_W-1:0]    r_sel;
    logic [TMR_W-1:0]    r_tmr;
    logic [GPIO_W-1:0]   r_pat;
    logic [GPIO_W-1:0]   r_gpio_out;
    logic [NREQ-1:0]     r_gnt;
    logic [NREQ-1:0]     r_done;
    logic                r_err;
    logic [GPIO_W-1:0]   r_err_mask;

    state_t              w_state_nxt;
    logic [PTR_W-1:0]    w_ptr_nxt;
    logic [PTR_W-1:0]    w_sel_nxt;
    logic [TMR_W-1:0]    w_tmr_nxt;
    logic [GPIO_W-1:0]   w_pat_nxt;
    logic [GPIO_W-1:0]   w_gpio_out_nxt;
    logic [NREQ-1:0]     w_gnt_nxt;
    logic [NREQ-1:0]     w_done_nxt;
    logic                w_err_nxt;
    logic [GPIO_W-1:0]   w_err_mask_nxt;

    logic                w_found;
    logic [PTR_W-1:0]    w_idx;
    logic [PTR_W-1:0]    w_sel;
    logic [PTR_W-1:0]    w_sel_inc;
    logic [GPIO_W-1:0]   w_pat_sel;
    logic [GPIO_W-1:0]   w_fail;

    // First requester at or after the pointer, wrapping at NREQ.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = PTR_W'((int'(r_ptr) + k) % NREQ);
            if (!w_found && i_req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    always_comb begin
        w_pat_sel = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_sel == PTR_W'(k)) w_pat_sel = i_pattern[k*GPIO_W +: GPIO_W];
        end
    end

    assign w_sel_inc = PTR_W'((int'(w_sel) + 1) % NREQ);
    // Only pattern bits are checked; host-driven extra bits are not errors.
    assign w_fail    = r_pat & ~i_gpio_in;

    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_sel_nxt      = r_sel;
        w_tmr_nxt      = r_tmr;
        w_pat_nxt      = r_pat;
        w_gpio_out_nxt = '0;
        w_gnt_nxt      = '0;
        w_done_nxt     = '0;
        w_err_nxt      = 1'b0;
        w_err_mask_nxt = r_err_mask;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt    = ST_DRIVE;
                    w_ptr_nxt      = w_sel_inc;
                    w_sel_nxt      = w_sel;
                    w_tmr_nxt      = TMR_W'(PULSE_LEN - 1);
                    w_pat_nxt      = w_pat_sel;
                    w_gpio_out_nxt = w_pat_sel;
                    w_gnt_nxt      = NREQ'(1) << w_sel;
                end
            end
            ST_DRIVE: begin
                if (r_tmr == '0) begin
                    w_state_nxt    = ST_GAP;
                    w_tmr_nxt      = TMR_W'(GAP_LEN - 1);
                    w_done_nxt     = NREQ'(1) << r_sel;
                    w_err_nxt      = |w_fail;
                    w_err_mask_nxt = w_fail;
                end else begin
                    w_tmr_nxt      = r_tmr - TMR_W'(1);
                    w_gpio_out_nxt = r_pat;
                end
            end
            ST_GAP: begin
                if (r_tmr == '0) w_state_nxt = ST_IDLE;
                else             w_tmr_nxt   = r_tmr - TMR_W'(1);
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_sel      <= '0;
            r_tmr      <= '0;
            r_pat      <= '0;
            r_gpio_out <= '0;
            r_gnt      <= '0;
            r_done     <= '0;
            r_err      <= 1'b0;
            r_err_mask <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_sel      <= w_sel_nxt;
            r_tmr      <= w_tmr_nxt;
            r_pat      <= w_pat_nxt;
            r_gpio_out <= w_gpio_out_nxt;
            r_gnt      <= w_gnt_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_err_mask <= w_err_mask_nxt;
        end
    end

    assign o_gpio_out = r_gpio_out;
    assign o_gnt      = r_gnt;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_err_mask = r_err_mask;
    assign o_busy     = (r_state != ST_IDLE);

    gpio_debounce #(
        .W        (GPIO_W),
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_gpio_in),
        .o_q     (o_in_filt),
        .o_rise  (o_rise),
        .o_fall  (o_fall)
    );

endmodule

// File: doc/ezusb_gpio_arbiter.md
Name: ezusb_gpio_arbiter

Overview:
Controller and arbiter that sits between user logic and the 4-bit wired-or GPIO interface of the default firmware (in[3:0] / out[3:0] vectors).
- Shares the output bits between NREQ requesters with a round-robin arbiter.
- Drives each granted 4-bit pattern as a timed pulse, then checks the readback to confirm the line was actually driven.
- Debounces the input vector and provides rise/fall event pulses to user logic.

Parameters:
NREQ, 4, number of requesters (2..8)
PULSE_LEN, 16, cycles a granted pattern is driven (must be >= 3)
GAP_LEN, 4, idle cycles with outputs released between grants (must be >= 1)
DEBOUNCE, 8, consecutive disagreeing cycles required before the filtered input changes (>= 1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
gpio_in  in  4  registered GPIO input vector (1 = line asserted)
gpio_out  out  4  GPIO output vector (1 = pull line low); registered
req  in  NREQ  per-requester request level
pattern  in  4*NREQ  per-requester pattern; requester i uses bits [4i+3:4i]
gnt  out  NREQ  one-cycle one-hot grant pulse
done  out  NREQ  one-cycle completion pulse to the granted requester
err  out  1  one-cycle pulse together with done when readback fails
err_mask  out  4  pattern bits that failed readback; held until the next done
busy  out  1  high in any state other than IDLE
in_filt  out  4  debounced input
rise  out  4  one-cycle pulse on each 0->1 transition of in_filt
fall  out  4  one-cycle pulse on each 1->0 transition of in_filt

Behaviour:
- Reset values: all outputs are 0, state is IDLE, round-robin pointer is 0, debounce counters are 0.
- Reset mid-operation: gpio_out is 0 on the next edge; no done or err pulse is generated.
- States: IDLE, DRIVE, GAP.
- IDLE, choosing a requester:
  - If any req bit is high, choose the first i with req[i]=1, searching from the pointer upward with wrap.
  - Latch pattern i into pat_q.
  - Set pointer to (i+1) mod NREQ.
  - Next cycle: state is DRIVE, gnt[i]=1 for that one cycle, gpio_out=pat_q.
- Timing example: req seen high at edge T gives gnt and gpio_out=pat_q from T+1.
- DRIVE:
  - gpio_out=pat_q for exactly PULSE_LEN cycles (T+1 .. T+PULSE_LEN).
  - In the last DRIVE cycle, compute fail = pat_q & ~gpio_in, using raw gpio_in, not in_filt.
- Leaving DRIVE (cycle T+PULSE_LEN+1):
  - gpio_out=0.
  - done[i]=1 and err_mask=fail.
  - err=1 if fail is non-zero.
  - State becomes GAP.
- GAP: lasts GAP_LEN cycles with gpio_out=0, then returns to IDLE. The earliest next gnt is at T+PULSE_LEN+GAP_LEN+2.
- Request handling:
  - Requests are levels. Deasserting req before it is granted withdraws it.
  - req changes during DRIVE or GAP are ignored.
  - pattern is sampled only at grant.
- Zero pattern: still occupies a full slot; it drives nothing and the readback always passes.
- Simultaneous requests: the pointer order decides; after a grant to i, requester i has the lowest priority.
- Debounce, per bit, independently:
  - Counter cnt counts cycles where gpio_in != in_filt; it clears to 0 on any cycle where they agree.
  - When gpio_in != in_filt and cnt == DEBOUNCE-1: in_filt toggles, cnt clears, and rise or fall pulses on that same cycle.
  - Counter width is clog2(DEBOUNCE+1) and the counter never overflows.
- Wired-or interaction: host-driven bits appearing on gpio_in while the arbiter drives other bits are not errors. Only pattern bits are checked.

Decomposition:
- Shared package ezusb_gpio_arbiter_pkg:
  - state enum (IDLE, DRIVE, GAP);
  - GPIO_W=4;
  - width helper for the counters;
  - parameter-legality check constants.
- One natural sub-module: gpio_debounce, with parameters W and DEBOUNCE and ports clk, reset, d[W-1:0], q, rise, fall. It is instantiated once with W=4.
- The arbiter and the DRIVE/GAP FSM stay in the top level.

Test Plan (defaults unless stated):
- Single request: req[2]=1, pattern2=4'b1010, gpio_in follows gpio_out with 1-cycle lag.
  - gnt=4'b0100 at T+1.
  - gpio_out=1010 during T+1..T+16.
  - done[2] at T+17 with err=0, err_mask=0.
  - busy low at T+21.
- Round robin: req=4'b1111 held, all patterns non-zero.
  - Grant order is 0,1,2,3,0.
  - Consecutive grants are 21 cycles apart (PULSE_LEN+GAP_LEN+1).
- Readback failure: pattern0=4'b0011, bench forces gpio_in[1]=0 throughout.
  - At T+17: done[0]=1, err=1, err_mask=4'b0010.
  - err_mask holds until the next done.
- Host-or and requests during busy:
  - Bench asserts gpio_in[3] while pattern=0001 is driven → no err.
  - req[1] pulsed only during DRIVE of req[0] → never granted.
- Debounce:
  - gpio_in[0] high for 7 cycles then low → no in_filt change.
  - High for 8 cycles → in_filt[0]=1 and rise[0] pulse on the 8th cycle.
  - Then low for 8 cycles → fall[0].
- Reset mid-DRIVE: reset asserted at T+5.
  - gpio_out=0 at T+6, and no done or err pulse.
  - After release, req=4'b0011 → gnt[0] first (pointer back to 0).
